// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage core pipeline control.
package core_pkg;

    localparam int REG_ADDR_W       = 5;
    localparam int DEFAULT_MAX_WAIT = 16;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_ERROR    = 2'd2
    } hz_state_e;

    // A load in EX feeding a source the ID instruction actually reads; x0 never stalls.
    function automatic logic load_use_hazard(
        input logic                  mem_read,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic [REG_ADDR_W-1:0] rs2,
        input logic                  use_rs1,
        input logic                  use_rs2
    );
        return mem_read && (rd != '0) &&
               ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats a same-cycle increment.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: stage enables/flushes for load-use, branch, fetch wait and dmem wait,
// with a dmem timeout trap and saturating stall/flush counters.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic                  use_rs1_id,
    input  logic                  use_rs2_id,
    input  logic [REG_ADDR_W-1:0] rd_ex,
    input  logic                  mem_read_ex,
    input  logic                  branch_taken_ex,
    input  logic                  mem_access_mem,
    input  logic                  dmem_ready,
    input  logic                  imem_ready,
    input  logic                  cnt_clr,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_write,
    output logic                  ex_mem_write,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  mem_wb_flush,
    output logic                  err_timeout,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    hz_state_e         state_q, state_nx;
    logic [WAIT_W-1:0] wait_q, wait_nx;
    logic              err_set;
    logic              freeze;
    logic              hazard;
    logic              stall_inc;
    logic              flush_inc;

    assign hazard = load_use_hazard(mem_read_ex, rd_ex, rs1_id, rs2_id, use_rs1_id, use_rs2_id);

    // Once waiting, only dmem_ready releases the freeze.
    assign freeze = (state_q == HZ_MEM_WAIT) ? !dmem_ready : (mem_access_mem && !dmem_ready);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= HZ_RUN;
            wait_q      <= '0;
            err_timeout <= 1'b0;
        end else begin
            state_q <= state_nx;
            wait_q  <= wait_nx;
            if (err_set) begin
                err_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        err_set      = 1'b0;
        state_nx     = state_q;
        wait_nx      = wait_q;

        if ((state_q == HZ_ERROR) || freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
            // The RUN cycle that detects the wait counts as the first wait cycle.
            if (state_q == HZ_RUN) begin
                stall_inc = 1'b1;
                state_nx  = HZ_MEM_WAIT;
                wait_nx   = WAIT_W'(1);
            end else if (state_q == HZ_MEM_WAIT) begin
                stall_inc = 1'b1;
                if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
                    state_nx = HZ_ERROR;
                    err_set  = 1'b1;
                end else begin
                    wait_nx = wait_q + WAIT_W'(1);
                end
            end
        end else begin
            state_nx = HZ_RUN;
            wait_nx  = '0;
            if (branch_taken_ex) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                flush_inc   = 1'b1;
            end else if (hazard) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                stall_inc   = 1'b1;
            end else if (!imem_ready) begin
                pc_write    = 1'b0;
                if_id_flush = 1'b1;
                stall_inc   = 1'b1;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (stall_inc),
        .clr    (cnt_clr),
        .cnt    (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (flush_inc),
        .clr    (cnt_clr),
        .cnt    (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with narrow counters and a short dmem timeout.
module tb_hazard_ctrl;

    localparam logic [6:0] C_RUN    = 7'b1111000;
    localparam logic [6:0] C_FREEZE = 7'b0000001;
    localparam logic [6:0] C_BRANCH = 7'b1111110;
    localparam logic [6:0] C_LDUSE  = 7'b0011010;
    localparam logic [6:0] C_IWAIT  = 7'b0111100;

    logic       clk = 1'b0;
    logic       arst_n;
    logic [4:0] rs1_id, rs2_id, rd_ex;
    logic       use_rs1_id, use_rs2_id, mem_read_ex, branch_taken_ex;
    logic       mem_access_mem, dmem_ready, imem_ready, cnt_clr;
    logic       pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic       if_id_flush, id_ex_flush, mem_wb_flush, err_timeout;
    logic [3:0] stall_cnt, flush_cnt;
    logic [6:0] ctl;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign ctl = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                  if_id_flush, id_ex_flush, mem_wb_flush};

    hazard_ctrl #(.CNT_W(4), .MAX_WAIT(4)) dut (
        .clk             (clk),
        .arst_n          (arst_n),
        .rs1_id          (rs1_id),
        .rs2_id          (rs2_id),
        .use_rs1_id      (use_rs1_id),
        .use_rs2_id      (use_rs2_id),
        .rd_ex           (rd_ex),
        .mem_read_ex     (mem_read_ex),
        .branch_taken_ex (branch_taken_ex),
        .mem_access_mem  (mem_access_mem),
        .dmem_ready      (dmem_ready),
        .imem_ready      (imem_ready),
        .cnt_clr         (cnt_clr),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .id_ex_write     (id_ex_write),
        .ex_mem_write    (ex_mem_write),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .mem_wb_flush    (mem_wb_flush),
        .err_timeout     (err_timeout),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rs1_id = '0; rs2_id = '0; rd_ex = '0;
        use_rs1_id = 1'b0; use_rs2_id = 1'b0; mem_read_ex = 1'b0;
        branch_taken_ex = 1'b0; mem_access_mem = 1'b0;
        dmem_ready = 1'b1; imem_ready = 1'b1; cnt_clr = 1'b0;
    endtask

    // Advance one clock; inputs change just after the edge, checks follow #2 later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        idle();
        arst_n = 1'b0;
        #2;
        check_eq("rst_ctl", 32'(ctl), 32'(C_RUN));
        check_eq("rst_stall", 32'(stall_cnt), 0);
        check_eq("rst_flush", 32'(flush_cnt), 0);
        check_eq("rst_err", 32'(err_timeout), 0);
        #10 arst_n = 1'b1;
        step();

        // T1 load-use on rs1
        mem_read_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; use_rs1_id = 1'b1;
        settle(); check_eq("t1_lduse", 32'(ctl), 32'(C_LDUSE));
        step();
        idle(); settle();
        check_eq("t1_next", 32'(ctl), 32'(C_RUN));
        check_eq("t1_stall", 32'(stall_cnt), 1);

        // T2 x0 destination and unused source
        mem_read_ex = 1'b1; rd_ex = 5'd0; rs1_id = 5'd0; use_rs1_id = 1'b1;
        settle(); check_eq("t2_x0", 32'(ctl), 32'(C_RUN));
        step();
        idle(); mem_read_ex = 1'b1; rd_ex = 5'd7; rs2_id = 5'd7; use_rs2_id = 1'b0;
        settle(); check_eq("t2_unused", 32'(ctl), 32'(C_RUN));
        step();
        check_eq("t2_stall", 32'(stall_cnt), 1);
        use_rs2_id = 1'b1;
        settle(); check_eq("t2_rs2", 32'(ctl), 32'(C_LDUSE));
        step();
        check_eq("t2_stall2", 32'(stall_cnt), 2);

        // T3 branch beats load-use
        branch_taken_ex = 1'b1;
        settle(); check_eq("t3_ctl", 32'(ctl), 32'(C_BRANCH));
        step();
        idle(); settle();
        check_eq("t3_flush", 32'(flush_cnt), 1);
        check_eq("t3_stall", 32'(stall_cnt), 2);

        // T4 three dmem wait cycles with a branch held in EX
        mem_access_mem = 1'b1; dmem_ready = 1'b0; branch_taken_ex = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle(); check_eq("t4_freeze", 32'(ctl), 32'(C_FREEZE));
            step();
        end
        check_eq("t4_stall", 32'(stall_cnt), 5);
        check_eq("t4_flush_held", 32'(flush_cnt), 1);
        dmem_ready = 1'b1;
        settle(); check_eq("t4_release", 32'(ctl), 32'(C_BRANCH));
        step();
        idle(); settle();
        check_eq("t4_flush", 32'(flush_cnt), 2);
        check_eq("t4_stall2", 32'(stall_cnt), 5);
        check_eq("t4_err", 32'(err_timeout), 0);

        // Fetch wait
        imem_ready = 1'b0;
        settle(); check_eq("iwait_ctl", 32'(ctl), 32'(C_IWAIT));
        step();
        idle(); settle();
        check_eq("iwait_stall", 32'(stall_cnt), 6);

        // T5 timeout after four wait cycles
        mem_access_mem = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        settle();
        check_eq("t5_err_early", 32'(err_timeout), 0);
        step();
        check_eq("t5_err", 32'(err_timeout), 1);
        check_eq("t5_stall", 32'(stall_cnt), 10);
        idle(); settle();
        check_eq("t5_stuck", 32'(ctl), 32'(C_FREEZE));
        step();
        check_eq("t5_hold", 32'(stall_cnt), 10);
        arst_n = 1'b0;
        settle();
        check_eq("t5_rst_err", 32'(err_timeout), 0);
        check_eq("t5_rst_stall", 32'(stall_cnt), 0);
        check_eq("t5_rst_flush", 32'(flush_cnt), 0);
        arst_n = 1'b1;
        step();
        settle(); check_eq("t5_run", 32'(ctl), 32'(C_RUN));

        // T6 saturation and clear priority
        imem_ready = 1'b0;
        for (int i = 0; i < 16; i++) step();
        check_eq("t6_sat", 32'(stall_cnt), 15);
        cnt_clr = 1'b1;
        step();
        check_eq("t6_clr", 32'(stall_cnt), 0);
        cnt_clr = 1'b0;
        step();
        check_eq("t6_after", 32'(stall_cnt), 1);
        idle(); branch_taken_ex = 1'b1;
        step();
        check_eq("t6_flush1", 32'(flush_cnt), 1);
        cnt_clr = 1'b1;
        step();
        check_eq("t6_flush_clr", 32'(flush_cnt), 0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
